// File: rtl/atm_txn_ctrl.sv
// Session/transaction controller for the ATM: PIN retries with lockout, menu operations,
// inactivity timeout and card eject. Sits downstream of the card-handling stage.
module atm_txn_ctrl #(
    parameter int balance_width  = 20,
    parameter int max_attempts   = 3,
    parameter int timeout_cycles = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     card_inserted,
    input  logic                     psw_submit,
    input  logic                     wrong_psw,
    input  logic [balance_width-1:0] balance,
    input  logic                     op_start,
    input  logic [1:0]               op_sel,
    input  logic [balance_width-1:0] amount,
    output logic                     op_done,
    output logic [balance_width-1:0] updated_balance,
    output logic [balance_width-1:0] shown_balance,
    output logic                     op_error,
    output logic                     card_out,
    output logic                     card_locked,
    output logic [2:0]               state_dbg
);

    localparam int BW = balance_width;
    localparam int TW = $clog2(timeout_cycles + 1);
    localparam int AW = $clog2(max_attempts + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PSW_WAIT  = 3'd1,
        PSW_CHECK = 3'd2,
        MENU      = 3'd3,
        COMMIT    = 3'd4,
        SETTLE    = 3'd5,
        EJECT     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_INQUIRY  = 2'b00,
        OP_WITHDRAW = 2'b01,
        OP_DEPOSIT  = 2'b10,
        OP_EXIT     = 2'b11
    } op_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [AW-1:0] attempts;

    logic [AW-1:0] attempts_inc;
    logic          lock_now;
    logic          timed_out;
    logic [BW:0]   sum_ext;
    logic          withdraw_bad;
    logic          deposit_bad;
    logic          timer_active;
    logic          timer_clear;

    assign attempts_inc = attempts + AW'(1);
    assign lock_now     = (attempts_inc == AW'(max_attempts));
    assign timed_out    = (timer == TW'(timeout_cycles));

    // Carry out of the BW+1 bit sum flags a deposit that would not fit in the balance.
    assign sum_ext      = {1'b0, balance} + {1'b0, amount};
    assign withdraw_bad = (amount == '0) || (amount > balance);
    assign deposit_bad  = (amount == '0) || sum_ext[BW];

    assign timer_active = (state == PSW_WAIT) || (state == MENU);
    assign timer_clear  = (state_next != state) || !timer_active
                        || (state == PSW_WAIT && psw_submit)
                        || (state == MENU && op_start);

    assign op_done   = (state == COMMIT);
    assign card_out  = (state == EJECT);
    assign state_dbg = state;

    // NOTE: every signal driven here gets its default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (card_inserted) state_next = PSW_WAIT;
            end
            PSW_WAIT: begin
                if (!card_inserted)   state_next = IDLE;
                else if (psw_submit)  state_next = PSW_CHECK;
                else if (timed_out)   state_next = EJECT;
            end
            PSW_CHECK: begin
                if (!card_inserted)   state_next = IDLE;
                else if (!wrong_psw)  state_next = MENU;
                else if (lock_now)    state_next = EJECT;
                else                  state_next = PSW_WAIT;
            end
            MENU: begin
                if (!card_inserted) begin
                    state_next = IDLE;
                end else if (op_start) begin
                    case (op_t'(op_sel))
                        OP_WITHDRAW: if (!withdraw_bad) state_next = COMMIT;
                        OP_DEPOSIT:  if (!deposit_bad)  state_next = COMMIT;
                        OP_EXIT:     state_next = EJECT;
                        default:     state_next = MENU;
                    endcase
                end else if (timed_out) begin
                    state_next = EJECT;
                end
            end
            // COMMIT always finishes so the card stage never sees a half-done transaction.
            COMMIT: state_next = SETTLE;
            SETTLE: begin
                if (!card_inserted) state_next = IDLE;
                else                state_next = MENU;
            end
            EJECT: begin
                if (!card_inserted) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            timer           <= '0;
            attempts        <= '0;
            updated_balance <= '0;
            shown_balance   <= '0;
            op_error        <= 1'b0;
            card_locked     <= 1'b0;
        end else begin
            state    <= state_next;
            op_error <= 1'b0;

            if (timer_clear)     timer <= '0;
            else if (!timed_out) timer <= timer + TW'(1);

            case (state)
                IDLE: begin
                    if (card_inserted) begin
                        attempts      <= '0;
                        card_locked   <= 1'b0;
                        shown_balance <= '0;
                    end
                end
                PSW_CHECK: begin
                    if (card_inserted) begin
                        if (!wrong_psw) begin
                            attempts <= '0;
                        end else begin
                            attempts <= attempts_inc;
                            if (lock_now) card_locked <= 1'b1;
                        end
                    end
                end
                MENU: begin
                    if (card_inserted && op_start) begin
                        case (op_t'(op_sel))
                            OP_INQUIRY: shown_balance <= balance;
                            OP_WITHDRAW: begin
                                if (withdraw_bad) op_error <= 1'b1;
                                else              updated_balance <= balance - amount;
                            end
                            OP_DEPOSIT: begin
                                if (deposit_bad) op_error <= 1'b1;
                                else             updated_balance <= sum_ext[BW-1:0];
                            end
                            default: ;
                        endcase
                    end
                end
                COMMIT: shown_balance <= updated_balance;
                EJECT: begin
                    if (!card_inserted) card_locked <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Directed bench for atm_txn_ctrl: login, lockout, withdraw/deposit/inquiry, errors,
// inactivity timeouts, reset mid-commit and card removal.
module tb_atm_txn_ctrl;

    localparam int BW = 20;

    localparam logic [2:0] S_IDLE = 3'd0, S_PW = 3'd1, S_PC = 3'd2, S_MENU = 3'd3,
                           S_COMMIT = 3'd4, S_SETTLE = 3'd5, S_EJECT = 3'd6;

    logic          clk = 1'b0;
    logic          rst;
    logic          card_inserted;
    logic          psw_submit;
    logic          wrong_psw;
    logic [BW-1:0] balance;
    logic          op_start;
    logic [1:0]    op_sel;
    logic [BW-1:0] amount;
    logic          op_done;
    logic [BW-1:0] updated_balance;
    logic [BW-1:0] shown_balance;
    logic          op_error;
    logic          card_out;
    logic          card_locked;
    logic [2:0]    state_dbg;

    int passed = 0;
    int total  = 0;

    atm_txn_ctrl #(.balance_width(BW), .max_attempts(3), .timeout_cycles(255)) dut (
        .clk             (clk),
        .rst             (rst),
        .card_inserted   (card_inserted),
        .psw_submit      (psw_submit),
        .wrong_psw       (wrong_psw),
        .balance         (balance),
        .op_start        (op_start),
        .op_sel          (op_sel),
        .amount          (amount),
        .op_done         (op_done),
        .updated_balance (updated_balance),
        .shown_balance   (shown_balance),
        .op_error        (op_error),
        .card_out        (card_out),
        .card_locked     (card_locked),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic login_ok();
        psw_submit = 1'b1;
        tick();
        psw_submit = 1'b0;
        wrong_psw  = 1'b0;
        tick();
    endtask

    task automatic start_op(input logic [1:0] sel, input logic [BW-1:0] amt);
        op_start = 1'b1;
        op_sel   = sel;
        amount   = amt;
        tick();
        op_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; card_inserted = 1'b0; psw_submit = 1'b0; wrong_psw = 1'b0;
        balance = '0; op_start = 1'b0; op_sel = 2'b00; amount = '0;
        ticks(2);
        rst = 1'b0;
        check("rst_state", state_dbg, S_IDLE);
        check("rst_op_done", op_done, 0);
        check("rst_card_out", card_out, 0);
        check("rst_locked", card_locked, 0);
        check("rst_shown", shown_balance, 0);
        check("rst_op_error", op_error, 0);

        // Withdraw 100 from 500
        card_inserted = 1'b1;
        balance = 20'd500;
        tick();
        check("ins_pw_wait", state_dbg, S_PW);
        psw_submit = 1'b1;
        tick();
        check("pw_check", state_dbg, S_PC);
        psw_submit = 1'b0;
        tick();
        check("login_menu", state_dbg, S_MENU);
        start_op(2'b01, 20'd100);
        check("wd_commit", state_dbg, S_COMMIT);
        check("wd_op_done", op_done, 1);
        check("wd_updated", updated_balance, 400);
        tick();
        check("wd_settle", state_dbg, S_SETTLE);
        check("wd_done_low", op_done, 0);
        check("wd_shown", shown_balance, 400);
        balance = 20'd400;
        tick();
        check("wd_menu_back", state_dbg, S_MENU);

        // Deposit 250 on 500, then inquiries
        balance = 20'd500;
        start_op(2'b10, 20'd250);
        check("dep_op_done", op_done, 1);
        check("dep_updated", updated_balance, 750);
        tick();
        check("dep_shown", shown_balance, 750);
        balance = 20'd750;
        tick();
        balance = 20'd123;
        start_op(2'b00, 20'd0);
        check("inq_state", state_dbg, S_MENU);
        check("inq_no_done", op_done, 0);
        check("inq_shown", shown_balance, 123);

        // Rejected operations
        balance = 20'd500;
        start_op(2'b01, 20'd600);
        check("over_wd_err", op_error, 1);
        check("over_wd_done", op_done, 0);
        check("over_wd_state", state_dbg, S_MENU);
        tick();
        check("err_pulse_end", op_error, 0);
        start_op(2'b01, 20'd0);
        check("zero_wd_err", op_error, 1);
        check("zero_wd_state", state_dbg, S_MENU);
        start_op(2'b10, 20'd0);
        check("zero_dep_err", op_error, 1);
        balance = 20'hFFFFF;
        start_op(2'b10, 20'd1);
        check("ovf_dep_err", op_error, 1);
        check("ovf_dep_done", op_done, 0);
        check("ovf_dep_state", state_dbg, S_MENU);
        balance = 20'hFFFFE;
        start_op(2'b10, 20'd1);
        check("max_dep_commit", state_dbg, S_COMMIT);
        check("max_dep_upd", updated_balance, 20'hFFFFF);
        check("max_dep_noerr", op_error, 0);
        ticks(2);
        balance = 20'd500;
        start_op(2'b01, 20'd500);
        check("all_wd_commit", state_dbg, S_COMMIT);
        check("all_wd_upd", updated_balance, 0);
        ticks(2);
        check("all_wd_menu", state_dbg, S_MENU);

        // MENU timeout: op_start after 254 idle cycles restarts the count
        ticks(254);
        start_op(2'b00, 20'd0);
        check("to_rearm_menu", state_dbg, S_MENU);
        ticks(255);
        check("to_edge_menu", state_dbg, S_MENU);
        tick();
        check("to_eject", state_dbg, S_EJECT);
        check("to_card_out", card_out, 1);
        check("to_not_locked", card_locked, 0);
        card_inserted = 1'b0;
        tick();
        check("to_idle", state_dbg, S_IDLE);
        check("to_card_out_clr", card_out, 0);

        // Lockout after three wrong PINs
        card_inserted = 1'b1;
        tick();
        for (int a = 1; a <= 3; a++) begin
            psw_submit = 1'b1;
            tick();
            psw_submit = 1'b0;
            wrong_psw  = 1'b1;
            tick();
            wrong_psw  = 1'b0;
            check($sformatf("wrong_%0d_state", a), state_dbg, (a == 3) ? S_EJECT : S_PW);
        end
        check("lock_flag", card_locked, 1);
        check("lock_card_out", card_out, 1);
        tick();
        check("lock_held", card_locked, 1);
        card_inserted = 1'b0;
        tick();
        check("lock_idle", state_dbg, S_IDLE);
        check("lock_clr", card_locked, 0);
        check("lock_out_clr", card_out, 0);

        // Two wrong PINs then a correct one reaches MENU
        card_inserted = 1'b1;
        tick();
        for (int a = 0; a < 2; a++) begin
            psw_submit = 1'b1;
            tick();
            psw_submit = 1'b0;
            wrong_psw  = 1'b1;
            tick();
            wrong_psw  = 1'b0;
        end
        login_ok();
        check("retry_menu", state_dbg, S_MENU);
        check("retry_unlocked", card_locked, 0);

        // Reset during COMMIT
        balance = 20'd500;
        start_op(2'b01, 20'd100);
        check("rst_pre_commit", op_done, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_commit_done", op_done, 0);
        check("rst_commit_idle", state_dbg, S_IDLE);

        // Exit operation
        tick();
        login_ok();
        start_op(2'b11, 20'd0);
        check("exit_eject", state_dbg, S_EJECT);
        check("exit_no_done", op_done, 0);
        card_inserted = 1'b0;
        tick();

        // PSW_WAIT timeout
        card_inserted = 1'b1;
        tick();
        ticks(255);
        check("pw_to_edge", state_dbg, S_PW);
        tick();
        check("pw_to_eject", state_dbg, S_EJECT);
        card_inserted = 1'b0;
        tick();

        // Card pulled in MENU while a withdraw is requested
        card_inserted = 1'b1;
        tick();
        login_ok();
        card_inserted = 1'b0;
        start_op(2'b01, 20'd100);
        check("pull_idle", state_dbg, S_IDLE);
        check("pull_no_done", op_done, 0);
        check("pull_no_err", op_error, 0);
        tick();
        check("pull_stay_idle", state_dbg, S_IDLE);
        check("pull_no_done2", op_done, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
